mem_burst_responder: RTL and testbench



---
 rtl/mem_if_pkg.sv | 30 +++
 rtl/mem_resp_ram.sv | 47 ++++
 rtl/mem_burst_responder.sv | 180 ++++++++++++++++++
 tb/tb_mem_burst_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the memory-side burst responder:
//   state_t      - responder FSM states
//   burst_len()  - beats per burst for a given block-offset width
//   wrap_offset()- critical-word-first beat offset, wrapping inside the block
// -----------------------------------------------------------------------------
package mem_if_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_BURST,
      WR_BURST,
      RELEASE
   } state_t;

   function automatic int unsigned burst_len(input int unsigned offset_width);
      return 32'd1 << offset_width;
   endfunction

   // Offset of beat 'beat' when the burst starts at 'start_off'; the carry out
   // of the offset field is discarded so the burst stays inside its block.
   function automatic int unsigned wrap_offset(input int unsigned start_off,
                                               input int unsigned beat,
                                               input int unsigned offset_width);
      return (start_off + beat) & (burst_len(offset_width) - 32'd1);
   endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// -----------------------------------------------------------------------------
// mem_resp_ram
// Synchronous 1R1W word array with a registered read port.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (read register only)
//   rd_en, rd_addr    read strobe and word index
//   rd_data           registered read word, holds when rd_en is low
//   wr_en, wr_addr,   write strobe, word index and data
//   wr_data
// -----------------------------------------------------------------------------
module mem_resp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the array sits in a clock-only process; giving it a reset branch
   // would turn every word into a resettable flop instead of a RAM macro.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/mem_burst_responder.sv
// -----------------------------------------------------------------------------
// mem_burst_responder
// Memory-side responder for the d_cache memory transaction interface. Serves one
// read or write block request at a time as a critical-word-first burst of
// 2^BLOCK_OFFSET_WIDTH words; reads start READ_LATENCY edges after accept.
// Ports:
//   i_Clk, i_Reset_n     clock (rising edge), asynchronous active-low reset
//   i_MEM_Valid          request valid, held for the whole transaction
//   i_MEM_Read_Write_n   1 = read, 0 = write
//   i_MEM_Address        halfword address of the critical word (bit 0 ignored)
//   i_MEM_Data           write word for the current beat
//   o_MEM_Valid          read beat valid
//   o_MEM_Data_Read      write beat consumed this cycle
//   o_MEM_Last           final beat of the burst
//   o_MEM_Data           read beat data
//   o_Busy               FSM not in IDLE
// -----------------------------------------------------------------------------
module mem_burst_responder
   import mem_if_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDRESS_WIDTH      = 22,
   parameter int BLOCK_OFFSET_WIDTH = 2,
   parameter int MEM_DEPTH_WIDTH    = 12,
   parameter int READ_LATENCY       = 4
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset_n,
   input  logic                     i_MEM_Valid,
   input  logic                     i_MEM_Read_Write_n,
   input  logic [ADDRESS_WIDTH-1:0] i_MEM_Address,
   input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
   output logic                     o_MEM_Valid,
   output logic                     o_MEM_Data_Read,
   output logic                     o_MEM_Last,
   output logic [DATA_WIDTH-1:0]    o_MEM_Data,
   output logic                     o_Busy
);

   localparam int unsigned BURST_LEN = burst_len(BLOCK_OFFSET_WIDTH);
   localparam int BLK_WIDTH = MEM_DEPTH_WIDTH - BLOCK_OFFSET_WIDTH;

   localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_BEAT =
      BLOCK_OFFSET_WIDTH'(BURST_LEN - 1);
   localparam logic [BLOCK_OFFSET_WIDTH-1:0] PEN_BEAT =
      BLOCK_OFFSET_WIDTH'(BURST_LEN - 2);
   // RD_WAIT leaves one edge before the first read is issued, and the read
   // register adds the final edge, hence the load value of latency-2.
   localparam logic [3:0] LAT_LOAD =
      (READ_LATENCY >= 2) ? 4'(READ_LATENCY - 2) : 4'd0;

   state_t                        state;
   logic [BLOCK_OFFSET_WIDTH-1:0] start_off_q;
   logic [BLOCK_OFFSET_WIDTH-1:0] beat_cnt;
   logic [BLK_WIDTH-1:0]          blk_q;
   logic [3:0]                    lat_cnt;

   logic [BLOCK_OFFSET_WIDTH-1:0] beat_off;
   logic [MEM_DEPTH_WIDTH-1:0]    beat_addr;
   logic                          ram_rd_en;
   logic                          ram_wr_en;
   logic                          unused_addr_bits;

   assign beat_off  = BLOCK_OFFSET_WIDTH'(wrap_offset(32'(start_off_q),
                                                      32'(beat_cnt),
                                                      BLOCK_OFFSET_WIDTH));
   assign beat_addr = {blk_q, beat_off};

   // Array traffic only while the initiator still holds the request; an abort
   // edge therefore neither reads nor commits a beat.
   assign ram_rd_en = (state == RD_BURST) && i_MEM_Valid;
   assign ram_wr_en = (state == WR_BURST) && i_MEM_Valid;

   // Address bits above the array depth alias; bit 0 is the halfword select.
   assign unused_addr_bits = ^{i_MEM_Address[ADDRESS_WIDTH-1:MEM_DEPTH_WIDTH+1],
                               i_MEM_Address[0]};

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state           <= IDLE;
         start_off_q     <= '0;
         blk_q           <= '0;
         beat_cnt        <= '0;
         lat_cnt         <= '0;
         o_MEM_Valid     <= 1'b0;
         o_MEM_Data_Read <= 1'b0;
         o_MEM_Last      <= 1'b0;
         o_Busy          <= 1'b0;
      end else if ((state inside {RD_WAIT, RD_BURST, WR_BURST}) && !i_MEM_Valid) begin
         // Abort: initiator withdrew mid-transaction.
         state           <= IDLE;
         beat_cnt        <= '0;
         lat_cnt         <= '0;
         o_MEM_Valid     <= 1'b0;
         o_MEM_Data_Read <= 1'b0;
         o_MEM_Last      <= 1'b0;
         o_Busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_MEM_Valid) begin
                  start_off_q <= i_MEM_Address[BLOCK_OFFSET_WIDTH:1];
                  blk_q       <= i_MEM_Address[MEM_DEPTH_WIDTH:BLOCK_OFFSET_WIDTH+1];
                  beat_cnt    <= '0;
                  o_Busy      <= 1'b1;
                  if (i_MEM_Read_Write_n) begin
                     lat_cnt <= LAT_LOAD;
                     state   <= (READ_LATENCY <= 1) ? RD_BURST : RD_WAIT;
                  end else begin
                     state           <= WR_BURST;
                     o_MEM_Data_Read <= 1'b1;
                     o_MEM_Last      <= (BURST_LEN == 1);
                  end
               end
            end

            RD_WAIT: begin
               if (lat_cnt == 4'd0) begin
                  state <= RD_BURST;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end

            // Each edge here issues one array read; its data and strobe
            // become visible together in the following cycle.
            RD_BURST: begin
               o_MEM_Valid <= 1'b1;
               o_MEM_Last  <= (beat_cnt == LAST_BEAT);
               beat_cnt    <= beat_cnt + 1'b1;
               if (beat_cnt == LAST_BEAT) begin
                  state <= RELEASE;
               end
            end

            // Each edge here commits the beat currently presented.
            WR_BURST: begin
               beat_cnt <= beat_cnt + 1'b1;
               if (beat_cnt == LAST_BEAT) begin
                  state           <= RELEASE;
                  o_MEM_Data_Read <= 1'b0;
                  o_MEM_Last      <= 1'b0;
               end else begin
                  o_MEM_Last <= (beat_cnt == PEN_BEAT);
               end
            end

            RELEASE: begin
               o_MEM_Valid     <= 1'b0;
               o_MEM_Data_Read <= 1'b0;
               o_MEM_Last      <= 1'b0;
               if (!i_MEM_Valid) begin
                  state  <= IDLE;
                  o_Busy <= 1'b0;
               end
            end

            default: begin
               state  <= IDLE;
               o_Busy <= 1'b0;
            end
         endcase
      end
   end

   mem_resp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (MEM_DEPTH_WIDTH)
   ) u_ram (
      .clk     (i_Clk),
      .rst_n   (i_Reset_n),
      .rd_en   (ram_rd_en),
      .rd_addr (beat_addr),
      .rd_data (o_MEM_Data),
      .wr_en   (ram_wr_en),
      .wr_addr (beat_addr),
      .wr_data (i_MEM_Data)
   );

endmodule

// File: tb/tb_mem_burst_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_responder
// Two responders (read latency 4 and 1) share one stimulus stream; writes land
// identically in both arrays, reads are observed on the selected instance.
// -----------------------------------------------------------------------------
module tb_mem_burst_responder;

   typedef logic [3:0][31:0] quad_t;

   typedef struct {
      bit          is_wr;
      bit          use_l1;
      logic [21:0] addr;
      quad_t       data;   // write data, or expected read beats in order
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic        rw;
   logic [21:0] addr;
   logic [31:0] wdata;

   logic        v4, dr4, l4, b4;
   logic [31:0] d4;
   logic        v1, dr1, l1, b1;
   logic [31:0] d1;

   logic        sel;
   logic        mv, ml, mb;
   logic [31:0] md;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_model [int];

   always #5 clk = ~clk;

   assign mv = sel ? v1 : v4;
   assign ml = sel ? l1 : l4;
   assign mb = sel ? b1 : b4;
   assign md = sel ? d1 : d4;

   mem_burst_responder #(.READ_LATENCY(4)) dut4 (
      .i_Clk              (clk),
      .i_Reset_n          (rst_n),
      .i_MEM_Valid        (valid),
      .i_MEM_Read_Write_n (rw),
      .i_MEM_Address      (addr),
      .i_MEM_Data         (wdata),
      .o_MEM_Valid        (v4),
      .o_MEM_Data_Read    (dr4),
      .o_MEM_Last         (l4),
      .o_MEM_Data         (d4),
      .o_Busy             (b4)
   );

   mem_burst_responder #(.READ_LATENCY(1)) dut1 (
      .i_Clk              (clk),
      .i_Reset_n          (rst_n),
      .i_MEM_Valid        (valid),
      .i_MEM_Read_Write_n (rw),
      .i_MEM_Address      (addr),
      .i_MEM_Data         (wdata),
      .o_MEM_Valid        (v1),
      .o_MEM_Data_Read    (dr1),
      .o_MEM_Last         (l1),
      .o_MEM_Data         (d1),
      .o_Busy             (b1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Array index of beat i: wrap inside the 4-word block, alias modulo 4096.
   function automatic int beat_idx(input logic [21:0] a, input int i);
      int w;
      int base;
      w    = int'(a >> 1);
      base = w - (w % 4);
      return (base + (w + i) % 4) % 4096;
   endfunction

   function automatic quad_t mk4(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d);
      return {d, c, b, a};
   endfunction

   // Write burst observed on dut4; abort_beat < 4 withdraws Valid in that beat.
   task automatic do_write(input logic [21:0] a, input quad_t d, input int abort_beat,
                           input string tag);
      sel   = 1'b0;
      valid = 1'b1;
      rw    = 1'b0;
      addr  = a;
      wdata = '0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (n == abort_beat) begin
            check($sformatf("%s abort beat%0d dr/last/busy", tag, n), {dr4, l4, b4}, {1'b1, 1'b0, 1'b1});
            valid = 1'b0;
            @(negedge clk);
            check($sformatf("%s after abort dr/last/busy", tag), {dr4, l4, b4}, 3'b000);
            return;
         end
         check($sformatf("%s beat%0d dr/last/busy", tag, n), {dr4, l4, b4}, {1'b1, (n == 3), 1'b1});
         wdata = d[n];
         mem_model[beat_idx(a, n)] = d[n];
      end
      @(negedge clk);
      check($sformatf("%s release dr/last/busy", tag), {dr4, l4, b4}, 3'b001);
      valid = 1'b0;
      @(negedge clk);
      check($sformatf("%s idle dr/last/busy", tag), {dr4, l4, b4}, 3'b000);
   endtask

   // Read burst on the selected instance; lat is the expected edge count from
   // accept to first visible beat; hold extra cycles of Valid in RELEASE.
   task automatic do_read(input bit s, input logic [21:0] a, input int lat, input quad_t exp,
                          input int hold, input string tag);
      int n;
      bit seen;
      sel   = s;
      valid = 1'b1;
      rw    = 1'b1;
      addr  = a;
      n     = 0;
      seen  = 1'b0;
      while (!seen && n < 32) begin
         @(negedge clk);
         n++;
         if (mv === 1'b1) seen = 1'b1;
      end
      check($sformatf("%s first-beat cycle", tag), n, lat + 1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("%s beat%0d valid/last", tag, i), {mv, ml}, {1'b1, (i == 3)});
         check($sformatf("%s beat%0d data", tag, i), md, exp[i]);
      end
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         check($sformatf("%s release%0d valid/last/busy", tag, h), {mv, ml, mb}, 3'b001);
      end
      valid = 1'b0;
      @(negedge clk);
      check($sformatf("%s idle valid/last/busy", tag), {mv, ml, mb}, 3'b000);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  tbl [12];
      quad_t q;
      int    n;
      bit    seen;

      tbl[0]  = '{1'b1, 1'b0, 22'h200,  mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3)};
      tbl[1]  = '{1'b0, 1'b0, 22'h204,  mk4(32'hA2, 32'hA3, 32'hA0, 32'hA1)};
      tbl[2]  = '{1'b0, 1'b0, 22'h205,  mk4(32'hA2, 32'hA3, 32'hA0, 32'hA1)};
      tbl[3]  = '{1'b1, 1'b0, 22'h300,  mk4(32'h11, 32'h22, 32'h33, 32'h44)};
      tbl[4]  = '{1'b0, 1'b0, 22'h300,  mk4(32'h11, 32'h22, 32'h33, 32'h44)};
      tbl[5]  = '{1'b1, 1'b0, 22'h30A,  mk4(32'h55, 32'h66, 32'h77, 32'h88)};
      tbl[6]  = '{1'b0, 1'b0, 22'h308,  mk4(32'h88, 32'h55, 32'h66, 32'h77)};
      tbl[7]  = '{1'b1, 1'b0, 22'h000,  mk4(32'hE0, 32'hE1, 32'hE2, 32'hE3)};
      tbl[8]  = '{1'b0, 1'b1, 22'h000,  mk4(32'hE0, 32'hE1, 32'hE2, 32'hE3)};
      tbl[9]  = '{1'b0, 1'b1, 22'h006,  mk4(32'hE3, 32'hE0, 32'hE1, 32'hE2)};
      tbl[10] = '{1'b1, 1'b0, 22'h2200, mk4(32'hB0, 32'hB1, 32'hB2, 32'hB3)};
      tbl[11] = '{1'b0, 1'b0, 22'h204,  mk4(32'hB2, 32'hB3, 32'hB0, 32'hB1)};

      sel   = 1'b0;
      valid = 1'b0;
      rw    = 1'b1;
      addr  = '0;
      wdata = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset dut4 v/dr/last/busy/data", {v4, dr4, l4, b4, d4}, 36'h0);
      check("reset dut1 v/dr/last/busy/data", {v1, dr1, l1, b1, d1}, 36'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset idle dut4", {v4, dr4, l4, b4}, 4'h0);

      // Directed table.
      for (int t = 0; t < 12; t++) begin
         if (tbl[t].is_wr)
            do_write(tbl[t].addr, tbl[t].data, 4, $sformatf("tbl%0d wr", t));
         else
            do_read(tbl[t].use_l1, tbl[t].addr, tbl[t].use_l1 ? 1 : 4, tbl[t].data, 0,
                    $sformatf("tbl%0d rd", t));
      end

      // Valid held in RELEASE: no new burst; one low cycle then re-accept.
      do_read(1'b0, 22'h300, 4, mk4(32'h11, 32'h22, 32'h33, 32'h44), 5, "hold rd");
      do_read(1'b0, 22'h300, 4, mk4(32'h11, 32'h22, 32'h33, 32'h44), 0, "reaccept rd");

      // Write aborted during beat 1: only beat 0 commits.
      do_write(22'h400, mk4(32'hD0, 32'hD1, 32'hD2, 32'hD3), 4, "pre wr");
      do_write(22'h400, mk4(32'hC0, 32'hC1, 32'hC2, 32'hC3), 1, "abort wr");
      do_read(1'b0, 22'h400, 4, mk4(32'hC0, 32'hD1, 32'hD2, 32'hD3), 0, "post-abort rd");

      // Read aborted in RD_WAIT.
      sel = 1'b0; valid = 1'b1; rw = 1'b1; addr = 22'h204;
      @(negedge clk);
      check("rd_wait valid/last/busy", {v4, l4, b4}, 3'b001);
      valid = 1'b0;
      @(negedge clk);
      check("rd_wait abort valid/last/busy", {v4, l4, b4}, 3'b000);

      // Asynchronous reset during RD_BURST.
      sel = 1'b0; valid = 1'b1; rw = 1'b1; addr = 22'h204;
      n = 0; seen = 1'b0;
      while (!seen && n < 32) begin
         @(negedge clk);
         n++;
         if (v4 === 1'b1) seen = 1'b1;
      end
      check("rst-burst first-beat cycle", n, 5);
      @(negedge clk);
      check("rst-burst beat1 valid/data", {v4, d4}, {1'b1, 32'hB3});
      #2 rst_n = 1'b0;
      #1;
      check("async reset valid/last/busy/data", {v4, l4, b4, d4}, 35'h0);
      valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_read(1'b0, 22'h204, 4, mk4(32'hB2, 32'hB3, 32'hB0, 32'hB1), 0, "fresh rd");

      // Randomized traffic against the array model.
      for (int t = 0; t < 40; t++) begin
         logic [21:0] a;
         bit          known;
         bit          s;
         a = 22'($urandom_range(0, 63) * 2 + $urandom_range(0, 1) * 8192 + $urandom_range(0, 1));
         known = 1'b1;
         for (int i = 0; i < 4; i++) known &= mem_model.exists(beat_idx(a, i));
         if (!known || $urandom_range(0, 2) == 0) begin
            for (int i = 0; i < 4; i++) q[i] = $urandom();
            do_write(a, q, 4, $sformatf("rnd%0d wr", t));
         end else begin
            for (int i = 0; i < 4; i++) q[i] = mem_model[beat_idx(a, i)];
            s = 1'($urandom_range(0, 1));
            do_read(s, a, s ? 1 : 4, q, int'($urandom_range(0, 2)), $sformatf("rnd%0d rd", t));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
